// File: rtl/camera_pkg.sv
// Shared types and helpers for the camera frame writer: FSM encoding,
// lane count and frame capacity.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SWAP    = 2'd2
  } cam_state_t;

  function automatic int unsigned lane_count(input int unsigned in_w, input int unsigned pix_w);
    return in_w / pix_w;
  endfunction

  // Decimation keeps one pixel in four, so capacity drops by 4.
  function automatic int unsigned frame_cap(input int unsigned h_res, input int unsigned v_res,
                                            input logic decim);
    return decim ? (h_res * v_res) / 4 : h_res * v_res;
  endfunction

endpackage

// File: rtl/pixel_decimator.sv
// Column/row position tracker for the incoming pixel stream; flags pixels
// that survive 2x2 decimation (even column of an even row).
module pixel_decimator #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_step,
  input  logic i_decim,
  output logic o_keep_c
);

  localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  // Row saturates on the last line so overflow pixels keep a stable row parity.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_step) begin
      if (r_col == COL_W'(H_RES - 1)) begin
        r_col <= '0;
        if (r_row != ROW_W'(V_RES - 1)) r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_keep_c = !i_decim || (!r_col[0] && !r_row[0]);

endmodule

// File: rtl/camera_frame_writer.sv
// Writes the selected byte lane of the camera pixel stream into one bank of a
// double-buffered frame BRAM; banks swap at frame end.
module camera_frame_writer
  import camera_pkg::*;
#(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 20,
  localparam int unsigned LANES  = lane_count(IN_W, PIX_W),
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pixel_valid,
  input  logic [IN_W-1:0]   data_in,
  input  logic              frame_done,
  input  logic [LANE_W-1:0] lane_sel,
  input  logic              decim,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              rd_bank,
  output logic              frame_ready,
  output logic              overflow,
  output logic              short_frame
);

  // One extra index bit so a full frame (index == capacity) is representable.
  localparam int unsigned IDX_W = ADDR_W;
  localparam logic [IDX_W-1:0] CAP_FULL = IDX_W'(frame_cap(H_RES, V_RES, 1'b0));
  localparam logic [IDX_W-1:0] CAP_DEC  = IDX_W'(frame_cap(H_RES, V_RES, 1'b1));

  cam_state_t        r_state, w_state_nxt;
  logic [LANE_W-1:0] r_lane;
  logic              r_decim;
  logic              r_bank;
  logic [IDX_W-1:0]  r_index;

  logic              w_start, w_done, w_pv, w_keep_c, w_accept, w_write, w_short;
  logic [IDX_W-1:0]  w_cap, w_idx_eff;
  logic [PIX_W-1:0]  w_pix;

  pixel_decimator #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_decim (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_start),
    .i_step   (w_pv),
    .i_decim  (r_decim),
    .o_keep_c (w_keep_c)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // frame_done outranks frame_start; a pixel alongside frame_done still counts.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_pv        = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_state_nxt = CAPTURE;
          w_start     = 1'b1;
        end
      end
      CAPTURE: begin
        if (frame_done) begin
          w_state_nxt = SWAP;
          w_done      = 1'b1;
          w_pv        = pixel_valid;
        end else if (frame_start) begin
          w_start = 1'b1;
        end else begin
          w_pv = pixel_valid;
        end
      end
      SWAP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_cap     = r_decim ? CAP_DEC : CAP_FULL;
  assign w_accept  = w_pv && w_keep_c;
  assign w_write   = w_accept && (r_index < w_cap);
  assign w_idx_eff = r_index + IDX_W'(w_write);
  assign w_short   = w_done && (w_idx_eff < w_cap);
  assign w_pix     = PIX_W'(data_in >> (32'(r_lane) * PIX_W));

  // The final write of a frame lands in the SWAP cycle using the old bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr        <= '0;
      we          <= 1'b0;
      pixel_out   <= '0;
      rd_bank     <= 1'b1;
      frame_ready <= 1'b0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
      r_lane      <= '0;
      r_decim     <= 1'b0;
      r_bank      <= 1'b0;
      r_index     <= '0;
    end else begin
      we          <= w_write;
      frame_ready <= w_done;
      if (w_write) begin
        addr      <= {r_bank, r_index[ADDR_W-2:0]};
        pixel_out <= w_pix;
        r_index   <= r_index + IDX_W'(1);
      end
      if (w_accept && !w_write) overflow <= 1'b1;
      if (w_start) begin
        r_lane      <= lane_sel;
        r_decim     <= decim;
        r_index     <= '0;
        overflow    <= 1'b0;
        short_frame <= 1'b0;
      end
      if (w_done) begin
        r_bank  <= ~r_bank;
        rd_bank <= ~rd_bank;
        if (w_short) short_frame <= 1'b1;
      end
      if (r_state == SWAP) addr <= {r_bank, (ADDR_W-1)'(0)};
    end
  end

endmodule
